// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its surroundings.
// The slave modport is the supervisor's view; master is the driver/observer side.
interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       slow_clk;
    logic       sys_rst_n;
    logic       slow_stb;
    logic       ready;
    logic       fault;
    logic [7:0] edge_count;

    modport slave (
        input  pll_locked,
        input  slow_clk,
        output sys_rst_n,
        output slow_stb,
        output ready,
        output fault,
        output edge_count
    );

    modport master (
        output pll_locked,
        output slow_clk,
        input  sys_rst_n,
        input  slow_stb,
        input  ready,
        input  fault,
        input  edge_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Holds the system in reset until PLL lock is stable and the fast/slow clock ratio checks out.
// Optional PLL_SUP_RUN_MONITOR_EN keeps checking the ratio in RUN and faults on a mismatch.
module pll_lock_supervisor #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RATIO              = 8,
    parameter int WINDOW_PERIODS     = 16,
    parameter int TOL                = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pll_lock_supervisor_if.slave  sup
);

    localparam int WIN_LEN = RATIO * WINDOW_PERIODS;
    localparam int STAB_W  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES + 1) : 1;
    localparam int WIN_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_ONE   = STAB_W'(1);
    localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(WIN_LEN - 1);
    localparam logic [WIN_W-1:0]  WIN_ONE    = WIN_W'(1);
    localparam logic [8:0]        EXP_EDGES  = 9'(WINDOW_PERIODS);
    localparam logic [8:0]        TOL_EDGES  = 9'(TOL);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_CHECK,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t state_q, state_d;

    logic              lock_s1_q, lock_s2_q;
    logic              slow_s1_q, slow_s2_q, slow_s3_q;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [7:0]        edge_cnt_q, edge_cnt_d;
    logic [7:0]        edge_count_q, edge_count_d;
    logic              fault_q, fault_d;
    logic              stb_q, stb_d;

    logic              locked_s;
    logic              slow_rise;
    logic              win_end;
    logic [7:0]        edge_total;
    logic [8:0]        abs_err;
    logic              ratio_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
            slow_s1_q <= 1'b0;
            slow_s2_q <= 1'b0;
            slow_s3_q <= 1'b0;
        end else begin
            lock_s1_q <= sup.pll_locked;
            lock_s2_q <= lock_s1_q;
            slow_s1_q <= sup.slow_clk;
            slow_s2_q <= slow_s1_q;
            slow_s3_q <= slow_s2_q;
        end
    end

    // A rising edge on the window's last cycle is included in edge_total before the compare.
    always_comb begin
        locked_s   = lock_s2_q;
        slow_rise  = slow_s2_q & ~slow_s3_q;
        win_end    = (win_cnt_q == WIN_LAST);
        edge_total = (edge_cnt_q == 8'hFF) ? 8'hFF : (edge_cnt_q + 8'(slow_rise));
        if ({1'b0, edge_total} >= EXP_EDGES) begin
            abs_err = {1'b0, edge_total} - EXP_EDGES;
        end else begin
            abs_err = EXP_EDGES - {1'b0, edge_total};
        end
        ratio_ok = (abs_err <= TOL_EDGES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = (LOCK_STABLE_CYCLES <= 1) ? ST_CHECK : ST_STABILIZE;
                end
            end
            ST_STABILIZE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (win_end) begin
                    state_d = ratio_ok ? ST_RUN : ST_FAULT;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end
`ifdef PLL_SUP_RUN_MONITOR_EN
                else if (win_end && !ratio_ok) begin
                    state_d = ST_FAULT;
                end
`endif
            end
            ST_FAULT: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            default: state_d = ST_WAIT_LOCK;
        endcase
    end

    // The cycle in which WAIT_LOCK first sees lock counts as the first stable cycle.
    always_comb begin
        stab_cnt_d   = '0;
        win_cnt_d    = '0;
        edge_cnt_d   = '0;
        edge_count_d = edge_count_q;
        fault_d      = fault_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    stab_cnt_d = STAB_ONE;
                end
            end
            ST_STABILIZE: begin
                stab_cnt_d = stab_cnt_q + STAB_ONE;
            end
            ST_CHECK, ST_RUN: begin
                if (win_end) begin
                    edge_count_d = edge_total;
                end else begin
                    win_cnt_d  = win_cnt_q + WIN_ONE;
                    edge_cnt_d = edge_total;
                end
            end
            default: ;
        endcase
        if ((state_d == ST_FAULT) && (state_q != ST_FAULT)) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt_q   <= '0;
            win_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            edge_count_q <= '0;
            fault_q      <= 1'b0;
            stb_q        <= 1'b0;
        end else begin
            stab_cnt_q   <= stab_cnt_d;
            win_cnt_q    <= win_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            edge_count_q <= edge_count_d;
            fault_q      <= fault_d;
            stb_q        <= stb_d;
        end
    end

    always_comb begin
        stb_d          = (state_q == ST_RUN) & slow_rise;
        sup.sys_rst_n  = (state_q == ST_RUN);
        sup.ready      = (state_q == ST_RUN);
        sup.slow_stb   = stb_q;
        sup.fault      = fault_q;
        sup.edge_count = edge_count_q;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Consumer-side companion to the system PLL: runs on the PLL's fast output clock, watches the PLL `locked` flag and the slow output clock (sampled as data), and releases the system reset only after lock has been stable and the fast/slow frequency ratio has been verified. It also provides a one-cycle strobe per slow-clock rising edge for symbol-rate logic, and flags a sticky fault on a ratio mismatch. It sits directly after the PLL, ahead of all modulator logic.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: consecutive `clk` cycles `locked` must hold before the ratio check starts.
- `RATIO`, default 8: expected `clk` cycles per `slow_clk` period (160 MHz / 20 MHz).
- `WINDOW_PERIODS`, default 16: expected `slow_clk` rising edges per measurement window. Window length W = RATIO*WINDOW_PERIODS `clk` cycles.
- `TOL`, default 1: allowed absolute edge-count error per window.

Ports:
- `clk` in 1: fast PLL output clock (160 MHz).
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock flag, asynchronous to `clk`.
- `slow_clk` in 1: slow PLL output clock, treated as asynchronous data.
- `sys_rst_n` out 1: active-low system reset; high only in RUN.
- `slow_stb` out 1: one-cycle pulse per detected `slow_clk` rising edge; emitted only in RUN.
- `ready` out 1: high in RUN.
- `fault` out 1: sticky ratio-fault flag; cleared only by `rst_n`.
- `edge_count` out 8: edge count of the last completed window; saturates at 255.

## Operation
- Synchronisers:
  - `pll_locked` passes through 2 flops to give `locked_s`.
  - `slow_clk` passes through 2 flops plus a history flop. A rising edge is `s2 & ~s3`.
- Counters:
  - Stability counter is wide enough for LOCK_STABLE_CYCLES.
  - Window counter runs 0..W-1.
  - Edge counter is 8-bit and saturating.
- FSM states: WAIT_LOCK, STABILIZE, CHECK, RUN, FAULT.
  - **WAIT_LOCK:** counters cleared. `locked_s`=1 → STABILIZE.
  - **STABILIZE:** stability counter increments each cycle.
    - `locked_s`=0 → WAIT_LOCK.
    - Count = LOCK_STABLE_CYCLES-1 → CHECK, with window and edge counters cleared.
  - **CHECK:** counts edges over exactly W cycles.
    - At window end, `edge_count` is loaded.
    - |count − WINDOW_PERIODS| ≤ TOL → RUN; otherwise → FAULT, and `fault` is set.
    - `locked_s`=0 at any time → WAIT_LOCK.
  - **RUN:** `sys_rst_n`=1, `ready`=1, `slow_stb` passes edges.
    - Windows repeat back to back; `edge_count` updates at each window end.
    - `locked_s`=0 → WAIT_LOCK; this has priority over a window-end result in the same cycle.
  - **FAULT:** `sys_rst_n`=0.
    - `locked_s`=0 → WAIT_LOCK, which retries the full sequence. `fault` stays 1.
- Edge on the last window cycle: counted in the ending window, before the compare. Next window starts at count 0.
- Outputs are decoded from the state register (glitch-free). `fault` and `edge_count` are registers.

## Timing
- Reset values: `sys_rst_n`=0, `slow_stb`=0, `ready`=0, `fault`=0, `edge_count`=0, state=WAIT_LOCK, all synchronisers 0.
- `rst_n` assertion forces reset values immediately (asynchronous), including mid-window.
- Lock-up latency: `sys_rst_n` rises LOCK_STABLE_CYCLES + W + 2 `clk` edges after the edge that first samples `pll_locked`=1, provided `locked` stays high and the ratio is good. With defaults this is 1154 edges.
- Lock loss: `sys_rst_n` falls 3 edges after the edge that first samples `pll_locked`=0.
- `slow_stb` latency: 3 `clk` edges after the edge that first samples `slow_clk`=1. Width is exactly 1 cycle.
- Ideal ratio: every window contains exactly WINDOW_PERIODS edges.

## Configuration
- `PLL_SUP_RUN_MONITOR_EN` defined: RUN keeps checking every window; a mismatch → FAULT and `fault`=1.
- Not defined: the ratio is checked once in CHECK. In RUN the window counter and `edge_count` still update, but no transition to FAULT occurs.

## Test plan
- `rst_n` low, then high; `pll_locked`=1; `slow_clk`=`clk`/8 → `sys_rst_n` and `ready` rise at edge 1154 (±0). `edge_count`=16.
- In RUN, pulse `slow_clk` high once → exactly one `slow_stb` pulse, 3 cycles later. Continuous 20 MHz input → one pulse every 8 cycles.
- `slow_clk`=`clk`/10 (12–13 edges per window) → FAULT after the CHECK window. `fault`=1, `sys_rst_n` stays 0. Drop and reassert `pll_locked` → sequence restarts; `fault` still 1.
- `pll_locked` drops for 1 cycle at STABILIZE count 500 → returns to WAIT_LOCK. `sys_rst_n` rises 1154 edges after re-lock.
- In RUN, drop `pll_locked` → `sys_rst_n`=0 exactly 3 edges later, and `slow_stb` is suppressed.
- With `PLL_SUP_RUN_MONITOR_EN` defined: switch to `clk`/10 in RUN → FAULT at the next window end. Without the macro → stays in RUN; `edge_count` shows 12 or 13.
